router_src_arb: RTL and testbench
=================================

# router_src_arb

Packet-granular round-robin arbiter that shares the router's single input port (pkt_valid/data_in/busy) among NUM_SRC packet sources. It sits directly in front of router_top, forwards the winning source's bytes with zero latency, locks the grant from header through parity byte, and stalls all other sources through their private busy lines.

## Interface
- NUM_SRC, 3: number of packet sources.
- DATA_W, 8: byte width; header is {payload_len[DATA_W-1:2], addr[1:0]}.
- clock  in  1  single clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- src_pkt_valid  in  NUM_SRC  per-source pkt_valid, high for header and payload, low on parity byte.
- src_data_in  in  NUM_SRC*DATA_W  per-source byte, source i in bits [i*DATA_W +: DATA_W].
- src_busy  out  NUM_SRC  per-source stall; source holds its byte while high.
- grant  out  NUM_SRC  one-hot current winner, 0 when nobody selected.
- busy  in  1  router_top busy.
- pkt_valid  out  1  to router_top.
- data_in  out  DATA_W  to router_top.
- pkt_done  out  1  one-cycle pulse the cycle after a parity byte is accepted.
- len_err  out  1  one-cycle pulse, present only with ROUTER_ARB_LEN_CHECK_EN.

## Operation
- States: IDLE, PKT. Transfer = posedge where winner's src_busy is low.
- IDLE: grant combinational = round-robin pick among asserted src_pkt_valid, search starting at rr_ptr; re-evaluated every IDLE cycle.
- IDLE, transfer with pick w: header accepted; latch w into grant register; state -> PKT; latch header payload_len into counter (check build).
- PKT: grant held from register; forward src_pkt_valid[w], src_data_in[w]; payload bytes transferred while src_pkt_valid[w]=1.
- PKT, transfer with src_pkt_valid[w]=0: parity byte accepted; state -> IDLE; rr_ptr = (w+1) mod NUM_SRC; pkt_done pulses next cycle.
- src_busy[i] = busy | (grant!=0 & !grant[i]); with no winner all sources see router busy.
- pkt_valid = grant!=0 ? src_pkt_valid[w] : 0; data_in = grant!=0 ? src_data_in[w] : 0.
- payload_len 0: header then parity directly; legal.
- Non-granted source asserting pkt_valid during PKT: held off, competes at next IDLE.
- Router busy in IDLE: pick shown on grant, nothing committed, pick may change.

## Timing
- Reset values: state IDLE, grant register 0, rr_ptr 0, pkt_valid 0, data_in 0, pkt_done 0, len_err 0, src_busy all 1 while resetn low.
- Source to router forwarding: combinational, 0 cycles.
- Header acceptance to grant lock: 1 edge; no bubble between packets from different sources beyond the parity cycle (IDLE re-arbitrates the next cycle).
- Reset asserted mid-packet: immediate return to IDLE, partial packet abandoned; no pkt_done/len_err.
- Back-to-back packets from same source with other requesters: other requester wins next.

## Configuration
- ROUTER_ARB_LEN_CHECK_EN defined: DATA_W-2 bit counter loaded from header, decremented per accepted payload byte; on parity acceptance, if counter != 0 or a payload byte arrived with counter already 0, len_err pulses next cycle (same cycle as pkt_done). Forwarding unaffected.
- Undefined: no counter, len_err port absent.

## Structure
- router_pkg: NUM_SRC, DATA_W defaults, state enum (IDLE, PKT), header field widths/offsets for payload_len and addr.
- Sub-module rr_arbiter: NUM_SRC requests + rr_ptr -> one-hot pick, purely combinational; FSM, grant register, mux and length counter in router_src_arb.

## Test plan
- Single source 0, payload_len 16, addr 2, busy 0 -> header 0x42, 16 payload bytes, parity forwarded unchanged; grant=001 for 18 cycles; pkt_done pulses once; len_err 0.
- Sources 0 and 2 request simultaneously from reset -> source 0 served first, src_busy[2]=1 throughout; source 2 header on data_in the cycle after source 0 parity.
- busy held high 5 cycles mid-payload of 14-byte packet -> data_in/pkt_valid stable, no byte lost or duplicated, all src_busy high.
- payload_len 0 packet from source 1 -> header then parity, PKT for 1 cycle, rr_ptr -> 2.
- Check build: header length 17, source sends 16 payload bytes -> len_err pulses with pkt_done; exact 17 -> no len_err.
- resetn low during payload of source 1 -> grant 0, pkt_valid 0, src_busy 111 immediately; after release, source 0 request wins (rr_ptr 0).

Source files
------------

// File: rtl/router_pkg.sv
// Shared defaults, header field layout and FSM state type for the router source arbiter.
package router_pkg;

    localparam int ROUTER_NUM_SRC = 3;
    localparam int ROUTER_DATA_W  = 8;

    // Header layout: {payload_len, addr}, addr in the low bits.
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam int LEN_LSB  = ADDR_LSB + ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_e;

    // Width of an index into n sources, never below 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/router_src_arb_if.sv
// Source-side and router-side byte bus shared by the arbiter (master) and its environment (slave).
interface router_src_arb_if
    import router_pkg::*;
#(
    parameter int NUM_SRC = ROUTER_NUM_SRC,
    parameter int DATA_W  = ROUTER_DATA_W
);

    logic [NUM_SRC-1:0]        src_pkt_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data_in;
    logic [NUM_SRC-1:0]        src_busy;
    logic                      busy;
    logic                      pkt_valid;
    logic [DATA_W-1:0]         data_in;

    modport master (
        input  src_pkt_valid, src_data_in, busy,
        output src_busy, pkt_valid, data_in
    );

    modport slave (
        output src_pkt_valid, src_data_in, busy,
        input  src_busy, pkt_valid, data_in
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot pick of the first asserted request at or after ptr.
module rr_arbiter
    import router_pkg::*;
#(
    parameter  int NUM_SRC = ROUTER_NUM_SRC,
    localparam int PTR_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] pick
);

    logic [PTR_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick = '0;
        idx  = '0;
        // Walk from the farthest candidate back to ptr; the last hit (closest to ptr) wins.
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            idx = PTR_W'((int'(ptr) + off) % NUM_SRC);
            if (req[idx]) begin
                pick = NUM_SRC'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/router_src_arb.sv
// Packet-granular round-robin arbiter in front of router_top; zero-latency byte mux, grant locked header..parity.
// Defining ROUTER_ARB_LEN_CHECK_EN adds a payload length checker and the len_err pulse.
module router_src_arb
    import router_pkg::*;
#(
    parameter int NUM_SRC = ROUTER_NUM_SRC,
    parameter int DATA_W  = ROUTER_DATA_W
) (
    input  logic               clock,
    input  logic               resetn,
    router_src_arb_if.master   bus,
    output logic [NUM_SRC-1:0] grant,
    output logic               pkt_done
`ifdef ROUTER_ARB_LEN_CHECK_EN
    ,
    output logic               len_err
`endif
);

    localparam int PTR_W = idx_w(NUM_SRC);

    arb_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [NUM_SRC-1:0] pick;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   next_ptr;
    logic               win_valid;
    logic [DATA_W-1:0]  win_data;
    logic               xfer;
    logic               done_d;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req  (bus.src_pkt_valid),
        .ptr  (rr_ptr_q),
        .pick (pick)
    );

    // Grant and all source stalls are gated by resetn so sources freeze the moment reset asserts.
    always_comb begin
        grant     = '0;
        win_valid = 1'b0;
        win_data  = '0;
        next_ptr  = '0;
        if (resetn) begin
            grant = (state_q == IDLE) ? pick : grant_q;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                win_valid = win_valid | bus.src_pkt_valid[i];
                win_data  = win_data | bus.src_data_in[i*DATA_W +: DATA_W];
                next_ptr  = PTR_W'((i + 1) % NUM_SRC);
            end
        end
        bus.pkt_valid = win_valid;
        bus.data_in   = win_data;
        bus.src_busy  = {NUM_SRC{~resetn | bus.busy}} | ((grant != '0) ? ~grant : '0);
        xfer          = (grant != '0) & ~bus.busy;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    grant_d = grant;
                    state_d = PKT;
                end
            end
            PKT: begin
                // Low pkt_valid on an accepted byte marks the parity byte: release the lock.
                if (xfer && !win_valid) begin
                    grant_d  = '0;
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            pkt_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_done <= done_d;
        end
    end

`ifdef ROUTER_ARB_LEN_CHECK_EN
    localparam int LEN_W = DATA_W - LEN_LSB;

    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic             over_q, over_d;
    logic             len_err_d;

    always_comb begin
        len_cnt_d = len_cnt_q;
        over_d    = over_q;
        len_err_d = 1'b0;
        if (xfer) begin
            if (state_q == IDLE) begin
                len_cnt_d = win_data[DATA_W-1:LEN_LSB];
                over_d    = 1'b0;
            end else if (win_valid) begin
                // A payload byte beyond the declared length is remembered until parity.
                if (len_cnt_q == '0) begin
                    over_d = 1'b1;
                end else begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                end
            end else begin
                len_err_d = over_q | (len_cnt_q != '0);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_cnt_q <= '0;
            over_q    <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            len_cnt_q <= len_cnt_d;
            over_q    <= over_d;
            len_err   <= len_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_router_src_arb.sv
// Scoreboard bench for router_src_arb: directed packets queue expected bytes, a negedge monitor checks them.
module tb_router_src_arb;
    import router_pkg::*;

    localparam int NS = 3;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    router_src_arb_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();
    logic [NS-1:0] grant;
    logic          pkt_done;
`ifdef ROUTER_ARB_LEN_CHECK_EN
    logic          len_err;
`endif

    router_src_arb #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus),
        .grant    (grant),
        .pkt_done (pkt_done)
`ifdef ROUTER_ARB_LEN_CHECK_EN
        ,
        .len_err  (len_err)
`endif
    );

    logic       vld [NS];
    logic [7:0] dat [NS];
    for (genvar g = 0; g < NS; g++) begin : g_src
        assign bus.src_pkt_valid[g]        = vld[g];
        assign bus.src_data_in[g*DW +: DW] = dat[g];
    end

    typedef struct {
        int         src;
        logic       vld;
        logic [7:0] data;
        bit         gap;
    } exp_t;

    exp_t exp_q[$];
    bit   done_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_xfer = -100;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pbyte(input logic [7:0] h, input int s, input int k);
        return h + 8'(17 * (k + 1)) + 8'(s * 64);
    endfunction

    function automatic logic [7:0] parity(input logic [7:0] h, input int s, input int n);
        logic [7:0] p = h;
        for (int k = 0; k < n; k++) p = p ^ pbyte(h, s, k);
        return p;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every accepted byte and every pkt_done pulse is matched against the queues.
    exp_t          mon_e;
    logic [NS-1:0] mon_g, mon_busy;
    bit            mon_lerr;
    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (grant != '0 && bus.busy == 1'b0) begin
                check("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e    = exp_q.pop_front();
                    mon_g    = NS'(1) << mon_e.src;
                    mon_busy = ~mon_g;
                    check("grant", grant, mon_g);
                    check("pkt_valid", bus.pkt_valid, mon_e.vld);
                    check("data_in", bus.data_in, mon_e.data);
                    check("src_busy", bus.src_busy, mon_busy);
                    if (mon_e.gap) check("no_bubble", cyc - last_xfer, 1);
                end
                last_xfer = cyc;
            end
            if (pkt_done) begin
                check("pkt_done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    mon_lerr = done_q.pop_front();
`ifdef ROUTER_ARB_LEN_CHECK_EN
                    check("len_err", len_err, mon_lerr);
`endif
                end
            end
        end
    end

    task automatic exp_pkt(input int s, input logic [7:0] h, input int n, input bit gap, input bit lerr);
        exp_q.push_back('{src: s, vld: 1'b1, data: h, gap: gap});
        for (int k = 0; k < n; k++) exp_q.push_back('{src: s, vld: 1'b1, data: pbyte(h, s, k), gap: 1'b0});
        exp_q.push_back('{src: s, vld: 1'b0, data: parity(h, s, n), gap: 1'b0});
        done_q.push_back(lerr);
    endtask

    // Present one byte and hold it until the source is not stalled at a rising edge.
    task automatic drive_byte(input int s, input logic v, input logic [7:0] d);
        int n = 0;
        vld[s] = v;
        dat[s] = d;
        forever begin
            @(negedge clock);
            if (bus.src_busy[s] == 1'b0) break;
            n++;
            if (n > 400) begin
                n_tests++;
                n_fail++;
                $display("FAIL src%0d_accept_timeout: stalled %0d cycles", s, n);
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send_pkt(input int s, input logic [7:0] h, input int n);
        drive_byte(s, 1'b1, h);
        for (int k = 0; k < n; k++) drive_byte(s, 1'b1, pbyte(h, s, k));
        drive_byte(s, 1'b0, parity(h, s, n));
        vld[s] = 1'b0;
        dat[s] = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 100) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        #1;
        check("drain_bytes", exp_q.size(), 0);
        check("drain_done", done_q.size(), 0);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < NS; i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
        end
        bus.busy = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        bus.busy = 1'b0;
        for (int i = 0; i < NS; i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
        end
        vld[0] = 1'b1;
        dat[0] = 8'h55;

        // Reset state, even with a source requesting.
        @(negedge clock);
        check("rst_grant", grant, 0);
        check("rst_pkt_valid", bus.pkt_valid, 0);
        check("rst_data_in", bus.data_in, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_src_busy", bus.src_busy, 3'b111);
        vld[0] = 1'b0;
        dat[0] = '0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        check("idle_src_busy", bus.src_busy, 3'b000);
        check("idle_grant", grant, 0);
        @(posedge clock);
        #1;

        // Single source 0: len 16, addr 2 -> header 0x42.
        exp_pkt(0, 8'h42, 16, 1'b0, 1'b0);
        send_pkt(0, 8'h42, 16);
        wait_drain();

        // Sources 0 and 2 together from reset: 0 first, 2 immediately after parity.
        do_reset();
        exp_pkt(0, 8'h08, 2, 1'b0, 1'b0);
        exp_pkt(2, 8'h0D, 3, 1'b1, 1'b0);
        fork
            send_pkt(0, 8'h08, 2);
            send_pkt(2, 8'h0D, 3);
        join
        wait_drain();

        // Router busy for 5 cycles in the middle of a 14-byte payload.
        exp_pkt(0, 8'h39, 14, 1'b0, 1'b0);
        fork
            send_pkt(0, 8'h39, 14);
            begin
                repeat (6) @(posedge clock);
                #1;
                bus.busy = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clock);
                    check("stall_src_busy", bus.src_busy, 3'b111);
                    check("stall_pkt_valid", bus.pkt_valid, 1);
                    check("stall_data_in", bus.data_in, pbyte(8'h39, 0, 5));
                end
                @(posedge clock);
                #1;
                bus.busy = 1'b0;
            end
        join
        wait_drain();

        // Zero-length packet from source 1, then all three request: pointer at 2.
        exp_pkt(1, 8'h03, 0, 1'b0, 1'b0);
        send_pkt(1, 8'h03, 0);
        wait_drain();
        exp_pkt(2, 8'h06, 1, 1'b0, 1'b0);
        exp_pkt(0, 8'h05, 1, 1'b1, 1'b0);
        exp_pkt(1, 8'h04, 1, 1'b1, 1'b0);
        fork
            send_pkt(0, 8'h05, 1);
            send_pkt(1, 8'h04, 1);
            send_pkt(2, 8'h06, 1);
        join
        wait_drain();

        // Move the pointer to 1, then abandon a source 1 packet with reset.
        exp_pkt(0, 8'h00, 0, 1'b0, 1'b0);
        send_pkt(0, 8'h00, 0);
        wait_drain();
        exp_q.push_back('{src: 1, vld: 1'b1, data: 8'h20, gap: 1'b0});
        for (int k = 0; k < 3; k++) exp_q.push_back('{src: 1, vld: 1'b1, data: pbyte(8'h20, 1, k), gap: 1'b0});
        drive_byte(1, 1'b1, 8'h20);
        for (int k = 0; k < 3; k++) drive_byte(1, 1'b1, pbyte(8'h20, 1, k));
        resetn = 1'b0;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_pkt_valid", bus.pkt_valid, 0);
        check("midrst_data_in", bus.data_in, 0);
        check("midrst_src_busy", bus.src_busy, 3'b111);
        check("midrst_bytes_seen", exp_q.size(), 0);
        vld[1] = 1'b0;
        dat[1] = '0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        exp_pkt(0, 8'h04, 1, 1'b0, 1'b0);
        exp_pkt(1, 8'h08, 2, 1'b1, 1'b0);
        fork
            send_pkt(0, 8'h04, 1);
            send_pkt(1, 8'h08, 2);
        join
        wait_drain();

        // Length mismatches: short by one, exact, and one byte over a zero length.
        exp_pkt(2, 8'h44, 16, 1'b0, 1'b1);
        send_pkt(2, 8'h44, 16);
        wait_drain();
        exp_pkt(2, 8'h44, 17, 1'b0, 1'b0);
        send_pkt(2, 8'h44, 17);
        wait_drain();
        exp_pkt(1, 8'h00, 1, 1'b0, 1'b1);
        send_pkt(1, 8'h00, 1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
